elevator_dispatcher: RTL and testbench
======================================

ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001: Parameter DWELL_CYCLES, default 4, door-open hold time in clk cycles after arrival (legal 1..255).
REQ-002: Parameter TOP_FLOOR, default 50, highest serviceable floor; floors are 0..TOP_FLOOR.
REQ-003: clk  input  1  system clock; all logic SHALL be sampled on its rising edge.
REQ-004: reset  input  1  reset, synchronous, active-high.
REQ-005: call_valid  input  1  a floor button press is presented this cycle.
REQ-006: call_floor  input  7  requested floor, unsigned.
REQ-007: car_floor  input  7  current floor reported by the car controller.
REQ-008: car_stop  input  1  car is stopped with door open.
REQ-009: req_floor  output  7  target floor driven to the car controller.
REQ-010: dir_up  output  1  current sweep direction, 1 = up, 0 = down.
REQ-011: busy  output  1  high in every state except IDLE.
REQ-012: arrived  output  1  one-cycle pulse when a pending floor is served.
REQ-013: call_err  output  1  one-cycle pulse when an out-of-range call is rejected.
REQ-014: pending_cnt  output  6  number of set bits in the pending map.

Function
REQ-015: Block SHALL keep a pending map pend[TOP_FLOOR:0], one bit per floor.
REQ-016: call_valid with call_floor <= TOP_FLOOR SHALL set pend[call_floor] on the next edge; duplicates are idempotent.
REQ-017: call_valid with call_floor > TOP_FLOOR SHALL leave pend unchanged and pulse call_err the next cycle.
REQ-018: States SHALL be IDLE, SELECT, MOVE, DWELL.
REQ-019: IDLE: req_floor SHALL equal car_floor (registered); pend != 0 -> SELECT.
REQ-020: SELECT (exactly 1 cycle): if dir_up, target = lowest pending floor >= car_floor; if none, target = highest pending floor < car_floor and dir_up clears; down direction symmetric (highest <= car_floor, else lowest > car_floor, dir_up sets); req_floor <= target; -> MOVE.
REQ-021: MOVE: each cycle the target SHALL be re-evaluated with the REQ-020 rule without direction flip, so a new call strictly between car_floor and req_floor in the sweep direction retargets next cycle.
REQ-022: MOVE: car_floor == req_floor and car_stop = 1 SHALL clear pend[req_floor], pulse arrived, load dwell counter with DWELL_CYCLES, -> DWELL.
REQ-023: DWELL: counter decrements each cycle; at 1 -> SELECT if pend != 0 else IDLE.
REQ-024: A call for the current floor in the arrival cycle or during DWELL SHALL be absorbed (bit not set, no arrived pulse).
REQ-025: Set and clear of the same bit in one cycle outside REQ-024: clear wins only for the served floor; other sets proceed.
REQ-026: pending_cnt SHALL reflect pend after the current edge's updates (registered, same cycle as pend).
REQ-027: req_floor SHALL never exceed TOP_FLOOR and SHALL change only in IDLE, SELECT, MOVE.

Reset
REQ-028: reset SHALL force state IDLE, pend = 0, req_floor = 0, dir_up = 1, busy = 0, arrived = 0, call_err = 0, pending_cnt = 0, dwell counter = 0.
REQ-029: reset SHALL take priority over calls and arrival in the same cycle; reset mid-MOVE or mid-DWELL discards all pending calls.

Verification
REQ-030: car_floor = 0, call 5 -> SELECT next cycle, req_floor = 5, dir_up = 1, busy = 1; car_floor = 5 with car_stop -> arrived 1 cycle, pend[5] = 0, DWELL 4 cycles, then IDLE.
REQ-031: car at 2 moving to 10, call 6 while car_floor = 4 -> req_floor = 6 next cycle; after serving 6, SELECT picks 10.
REQ-032: car at 8, dir_up, pending {3, 12} -> serve 12 first, then dir_up = 0, req_floor = 3.
REQ-033: call_floor = 51 -> call_err pulse, pending_cnt unchanged; call_floor = 50 -> accepted, pending_cnt + 1.
REQ-034: calls 7, 7, 9 back to back -> pending_cnt = 2; call 7 during DWELL at floor 7 -> absorbed, pending_cnt unchanged.
REQ-035: reset asserted in MOVE with pending_cnt = 3 -> next cycle all outputs at REQ-028 values, state IDLE.

Source files
------------

// File: rtl/elevator_dispatcher.sv
// Elevator dispatcher: keeps one pending-call bit per floor and runs a
// sweep (SCAN) policy. It picks the next floor in the current direction
// and reverses only when nothing is left ahead of the car. In MOVE it
// retargets to a closer floor that is requested along the way.
module elevator_dispatcher #(
  parameter int DWELL_CYCLES = 4,
  parameter int TOP_FLOOR    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       call_valid,
  input  logic [6:0] call_floor,
  input  logic [6:0] car_floor,
  input  logic       car_stop,
  output logic [6:0] req_floor,
  output logic       dir_up,
  output logic       busy,
  output logic       arrived,
  output logic       call_err,
  output logic [5:0] pending_cnt
);

  localparam int         NF       = TOP_FLOOR + 1;
  localparam logic [6:0] TOP_F    = 7'(TOP_FLOOR);
  localparam logic [7:0] DWELL_LD = 8'(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE, SELECT, MOVE, DWELL} state_t;

  typedef struct packed {
    logic       found;
    logic       flip;
    logic [6:0] floor;
  } tgt_t;

  state_t        state, state_nxt;
  logic [NF-1:0] pend, pend_set, pend_nxt, set_vec, clr_vec;
  logic [7:0]    dwell_cnt, dwell_nxt;
  logic [6:0]    req_nxt;
  logic          dir_nxt;
  logic          call_ok, call_bad, arrive, absorb;
  tgt_t          tgt;

  // The car controller may report a floor above the serviceable range.
  // The target it is given must still stay legal.
  function automatic logic [6:0] clamp_floor(input logic [6:0] f);
    return (f > TOP_F) ? TOP_F : f;
  endfunction

  // Sweep rule. The forward candidate is the nearest pending floor at or
  // ahead of the car in direction 'up'. When there is none, the reverse
  // candidate is the nearest pending floor behind the car, and flip
  // reports that the direction would have to change.
  function automatic tgt_t find_target(input logic [NF-1:0] map,
                                       input logic [6:0]    pos,
                                       input logic          up);
    tgt_t       r;
    logic       fwd_ok, rev_ok;
    logic [6:0] fwd, rev;
    int         p;
    p      = int'(pos);
    fwd_ok = 1'b0;
    rev_ok = 1'b0;
    fwd    = '0;
    rev    = '0;
    if (up) begin
      for (int i = NF - 1; i >= 0; i--)
        if (map[i] && i >= p) begin fwd_ok = 1'b1; fwd = 7'(i); end
      for (int i = 0; i < NF; i++)
        if (map[i] && i < p) begin rev_ok = 1'b1; rev = 7'(i); end
    end else begin
      for (int i = 0; i < NF; i++)
        if (map[i] && i <= p) begin fwd_ok = 1'b1; fwd = 7'(i); end
      for (int i = NF - 1; i >= 0; i--)
        if (map[i] && i > p) begin rev_ok = 1'b1; rev = 7'(i); end
    end
    r.found = fwd_ok | rev_ok;
    r.flip  = !fwd_ok && rev_ok;
    r.floor = fwd_ok ? fwd : rev;
    return r;
  endfunction

  function automatic logic [5:0] count_ones(input logic [NF-1:0] map);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NF; i++) c = c + {5'd0, map[i]};
    return c;
  endfunction

  assign busy = (state != IDLE);

  // Decode the incoming call and the arrival event into per-floor set/clear masks.
  always_comb begin
    call_ok  = call_valid && (call_floor <= TOP_F);
    call_bad = call_valid && (call_floor > TOP_F);
    arrive   = (state == MOVE) && (car_floor == req_floor) && car_stop;
    // A call for the floor the door is open at is already satisfied.
    absorb   = (call_floor == car_floor) && (arrive || state == DWELL);
    set_vec  = '0;
    clr_vec  = '0;
    for (int i = 0; i < NF; i++) begin
      set_vec[i] = call_ok && !absorb && (call_floor == 7'(i));
      clr_vec[i] = arrive && (req_floor == 7'(i));
    end
    // Decisions see this cycle's call. Clearing the served floor wins over a same-cycle set.
    pend_set = pend | set_vec;
    pend_nxt = pend_set & ~clr_vec;
  end

  // Next-state, target and direction selection.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_floor;
    dir_nxt   = dir_up;
    dwell_nxt = dwell_cnt;
    tgt       = find_target(pend_set, car_floor, dir_up);
    case (state)
      IDLE: begin
        req_nxt = clamp_floor(car_floor);
        if (|pend_set) state_nxt = SELECT;
      end
      SELECT: begin
        if (tgt.found) begin
          req_nxt   = tgt.floor;
          if (tgt.flip) dir_nxt = !dir_up;
          state_nxt = MOVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      MOVE: begin
        if (arrive) begin
          dwell_nxt = DWELL_LD;
          state_nxt = DWELL;
        end else if (tgt.found && !tgt.flip) begin
          // Retargeting never reverses the sweep mid-travel.
          req_nxt = tgt.floor;
        end
      end
      DWELL: begin
        dwell_nxt = (dwell_cnt == 8'd0) ? 8'd0 : dwell_cnt - 8'd1;
        if (dwell_cnt <= 8'd1) state_nxt = (|pend_set) ? SELECT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pending map and registered outputs. Reset overrides any same-cycle call or arrival.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= '0;
      req_floor   <= '0;
      dir_up      <= 1'b1;
      arrived     <= 1'b0;
      call_err    <= 1'b0;
      pending_cnt <= '0;
      dwell_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      req_floor   <= req_nxt;
      dir_up      <= dir_nxt;
      arrived     <= arrive;
      call_err    <= call_bad;
      pending_cnt <= count_ones(pend_nxt);
      dwell_cnt   <= dwell_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher: a table of per-cycle vectors plus
// hand-written sequences for retargeting, reversal, reset and clamping.
module tb_elevator_dispatcher;

  logic       clk;
  logic       reset;
  logic       call_valid;
  logic [6:0] call_floor;
  logic [6:0] car_floor;
  logic       car_stop;
  logic [6:0] req_floor;
  logic       dir_up;
  logic       busy;
  logic       arrived;
  logic       call_err;
  logic [5:0] pending_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [6:0] cf;
    logic [6:0] car;
    logic       stop;
    logic [6:0] e_req;
    logic       e_dir;
    logic       e_busy;
    logic       e_arr;
    logic       e_err;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  elevator_dispatcher #(.DWELL_CYCLES(4), .TOP_FLOOR(50)) dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .car_floor(car_floor), .car_stop(car_stop), .req_floor(req_floor),
    .dir_up(dir_up), .busy(busy), .arrived(arrived), .call_err(call_err),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic apply(input logic rst, input logic cv, input logic [6:0] cf,
                       input logic [6:0] car, input logic stop);
    reset      = rst;
    call_valid = cv;
    call_floor = cf;
    car_floor  = car;
    car_stop   = stop;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic cv, input logic [6:0] cf,
                     input logic [6:0] car, input logic stop,
                     input logic [6:0] e_req, input logic e_dir, input logic e_busy,
                     input logic e_arr, input logic e_err, input logic [5:0] e_cnt);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cf = cf; v.car = car; v.stop = stop;
    v.e_req = e_req; v.e_dir = e_dir; v.e_busy = e_busy;
    v.e_arr = e_arr; v.e_err = e_err; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag, input int e_req, input int e_dir,
                         input int e_busy, input int e_arr, input int e_err,
                         input int e_cnt);
    chk({tag, ".req_floor"},   int'(req_floor),   e_req);
    chk({tag, ".dir_up"},      int'(dir_up),      e_dir);
    chk({tag, ".busy"},        int'(busy),        e_busy);
    chk({tag, ".arrived"},     int'(arrived),     e_arr);
    chk({tag, ".call_err"},    int'(call_err),    e_err);
    chk({tag, ".pending_cnt"}, int'(pending_cnt), e_cnt);
  endtask

  initial begin
    reset = 1'b1; call_valid = 1'b0; call_floor = '0; car_floor = '0; car_stop = 1'b0;

    //  rst cv  cf  car stop | req dir busy arr err cnt
    add(1, 0,  0,  0, 0,     0, 1, 0, 0, 0, 0);  // reset values
    add(0, 1,  5,  0, 0,     0, 1, 1, 0, 0, 1);  // call 5 -> SELECT
    add(0, 0,  0,  0, 0,     5, 1, 1, 0, 0, 1);  // target 5
    add(0, 0,  0,  3, 0,     5, 1, 1, 0, 0, 1);
    add(0, 0,  0,  5, 1,     5, 1, 1, 1, 0, 0);  // arrival
    add(0, 0,  0,  5, 1,     5, 1, 1, 0, 0, 0);  // dwell
    add(0, 0,  0,  5, 1,     5, 1, 1, 0, 0, 0);
    add(0, 0,  0,  5, 1,     5, 1, 1, 0, 0, 0);
    add(0, 0,  0,  5, 1,     5, 1, 0, 0, 0, 0);  // IDLE after 4 dwell cycles
    add(0, 0,  0,  5, 0,     5, 1, 0, 0, 0, 0);
    add(0, 1, 51,  5, 0,     5, 1, 0, 0, 1, 0);  // out of range -> call_err
    add(0, 1, 50,  5, 0,     5, 1, 1, 0, 0, 1);  // top floor accepted
    add(0, 0,  0,  5, 0,    50, 1, 1, 0, 0, 1);
    add(0, 0,  0, 50, 1,    50, 1, 1, 1, 0, 0);  // arrive at 50
    add(0, 1, 50, 50, 1,    50, 1, 1, 0, 0, 0);  // absorbed during dwell
    add(0, 1,  3, 50, 1,    50, 1, 1, 0, 0, 1);  // other floor accepted in dwell
    add(0, 0,  0, 50, 1,    50, 1, 1, 0, 0, 1);
    add(0, 0,  0, 50, 1,    50, 1, 1, 0, 0, 1);  // -> SELECT
    add(0, 0,  0, 50, 0,     3, 0, 1, 0, 0, 1);  // reverse down to 3
    add(0, 0,  0,  3, 1,     3, 0, 1, 1, 0, 0);  // arrive at 3
    add(0, 1,  7,  3, 1,     3, 0, 1, 0, 0, 1);  // call 7
    add(0, 1,  7,  3, 1,     3, 0, 1, 0, 0, 1);  // duplicate 7
    add(0, 1,  9,  3, 1,     3, 0, 1, 0, 0, 2);  // call 9
    add(0, 0,  0,  3, 1,     3, 0, 1, 0, 0, 2);  // -> SELECT
    add(0, 0,  0,  3, 0,     7, 1, 1, 0, 0, 2);  // reverse up to 7
    add(0, 0,  0,  7, 1,     7, 1, 1, 1, 0, 1);  // arrive at 7
    add(0, 1,  7,  7, 1,     7, 1, 1, 0, 0, 1);  // call 7 absorbed
    add(0, 0,  0,  7, 1,     7, 1, 1, 0, 0, 1);
    add(0, 0,  0,  7, 1,     7, 1, 1, 0, 0, 1);
    add(0, 0,  0,  7, 1,     7, 1, 1, 0, 0, 1);  // -> SELECT
    add(0, 0,  0,  7, 0,     9, 1, 1, 0, 0, 1);  // next up: 9

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].cv, tbl[i].cf, tbl[i].car, tbl[i].stop);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].e_req), int'(tbl[i].e_dir),
              int'(tbl[i].e_busy), int'(tbl[i].e_arr), int'(tbl[i].e_err),
              int'(tbl[i].e_cnt));
    end

    // Retarget mid-move: car 2 heading to 10, call 6 at floor 4.
    apply(1, 0, 0, 2, 0);
    apply(0, 1, 10, 2, 0);
    apply(0, 0, 0, 2, 0);
    chk("retgt.req_initial", int'(req_floor), 10);
    apply(0, 0, 0, 3, 0);
    apply(0, 1, 6, 4, 0);
    chk("retgt.req_6", int'(req_floor), 6);
    apply(0, 0, 0, 6, 1);
    chk("retgt.arrived", int'(arrived), 1);
    chk("retgt.cnt", int'(pending_cnt), 1);
    for (int k = 0; k < 4; k++) apply(0, 0, 0, 6, 1);
    apply(0, 0, 0, 6, 0);
    chk("retgt.req_10", int'(req_floor), 10);
    chk("retgt.dir", int'(dir_up), 1);

    // Reversal: car 8 going up, pending {3,12}: 12 first, then down to 3.
    apply(1, 0, 0, 8, 0);
    apply(0, 1, 3, 8, 0);
    apply(0, 1, 12, 8, 0);
    chk("rev.req_12", int'(req_floor), 12);
    chk("rev.dir_up", int'(dir_up), 1);
    chk("rev.cnt2", int'(pending_cnt), 2);
    apply(0, 0, 0, 12, 1);
    chk("rev.arrived", int'(arrived), 1);
    for (int k = 0; k < 4; k++) apply(0, 0, 0, 12, 1);
    apply(0, 0, 0, 12, 0);
    chk("rev.req_3", int'(req_floor), 3);
    chk("rev.dir_down", int'(dir_up), 0);

    // Reset mid-MOVE with three pending calls, colliding with a call and an arrival.
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 20, 0, 0);
    apply(0, 1, 30, 0, 0);
    apply(0, 1, 40, 0, 0);
    chk("rst.cnt3", int'(pending_cnt), 3);
    chk("rst.req20", int'(req_floor), 20);
    apply(1, 1, 45, 20, 1);
    chk_all("rst", 0, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 20, 0);
    chk("rst.idle_busy", int'(busy), 0);
    chk("rst.idle_cnt", int'(pending_cnt), 0);
    chk("rst.idle_req", int'(req_floor), 20);

    // Car reporting a floor above the top must not push req_floor out of range.
    apply(0, 0, 0, 60, 0);
    chk("clamp.req", int'(req_floor), 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
